// File: rtl/dl_div_if.sv
// Request/result bus between a DLFloat16 divider and its client.
// The master drives start/operands; the slave returns status and the quotient.
interface dl_div_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] c_div;
    logic        div_zero;

    modport master (
        output start, a, b,
        input  busy, done, c_div, div_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, c_div, div_zero
    );
endinterface

// File: rtl/dl_div.sv
// DLFloat16 divider: 11-step restoring mantissa divide, one normalise cycle,
// and a single-cycle path for FFFF / divide-by-zero / zero-dividend operands.
//
// state   | meaning
// IDLE    | waiting for start; operands and specials resolved on the start edge
// DIV     | one restoring quotient bit per cycle, 11 cycles
// NORM    | exponent adjust, overflow/underflow clamp, result registered
// DONE    | done pulse, always back to IDLE
module dl_div (
    input logic     clk,
    input logic     rst,
    dl_div_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [10:0] rem_q, rem_d;
    logic [9:0]  div_q, div_d;
    logic [10:0] q_q, q_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        s_q, s_d;
    logic [5:0]  ea_q, ea_d;
    logic [5:0]  eb_q, eb_d;
    logic [15:0] c_div_q, c_div_d;
    logic        div_zero_q, div_zero_d;

    logic        rem_ge;
    logic [10:0] rem_sub;
    logic signed [7:0] e_norm;
    logic [8:0]  frac_norm;

    assign rem_ge  = (rem_q >= {1'b0, div_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    // Quotient lies in [0.5, 2): q[10] tells whether a one-place left shift is needed.
    assign e_norm    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                     + (q_q[10] ? 8'sd31 : 8'sd30);
    assign frac_norm = q_q[10] ? q_q[9:1] : q_q[8:0];

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        div_d      = div_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        c_div_d    = c_div_q;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.a == 16'hFFFF || bus.b == 16'hFFFF) begin
                        c_div_d    = 16'hFFFF;
                        div_zero_d = 1'b0;
                        state_d    = ST_DONE;
                    end else if (bus.b == 16'h0000) begin
                        c_div_d    = 16'hFFFF;
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (bus.a == 16'h0000) begin
                        c_div_d    = 16'h0000;
                        div_zero_d = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        rem_d   = {2'b01, bus.a[8:0]};
                        div_d   = {1'b1, bus.b[8:0]};
                        q_d     = '0;
                        cnt_d   = '0;
                        s_d     = bus.a[15] ^ bus.b[15];
                        ea_d    = bus.a[14:9];
                        eb_d    = bus.b[14:9];
                        state_d = ST_DIV;
                    end
                end
            end

            ST_DIV: begin
                q_d   = {q_q[9:0], rem_ge};
                rem_d = rem_sub << 1;
                if (cnt_q == 4'd10) begin
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_NORM: begin
                if (e_norm <= 8'sd0) begin
                    c_div_d = 16'h0000;
                end else if (e_norm == 8'sd63) begin
                    c_div_d = 16'hFFFF;
                end else if (e_norm > 8'sd63) begin
                    c_div_d = s_q ? 16'hFDFE : 16'h7DFE;
                end else begin
                    c_div_d = {s_q, e_norm[5:0], frac_norm};
                end
                div_zero_d = 1'b0;
                state_d    = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            div_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            c_div_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            c_div_q    <= c_div_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q == ST_DIV) || (state_q == ST_NORM);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.c_div    = c_div_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_dl_div.sv
// Self-checking bench for dl_div: directed vectors, specials, ignored starts,
// mid-divide reset and randomised back-to-back operations against a reference model.
module tb_dl_div;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dl_div_if bus ();

    dl_div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic        dz;
        int          lat;
        int          busy;
    } exp_t;

    exp_t sb[$];

    function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
        return (a == 16'hFFFF) || (b == 16'hFFFF) || (b == 16'h0000) || (a == 16'h0000);
    endfunction

    // Reference: integer division of the 10-bit significands, then normalise/clamp.
    function automatic logic [16:0] model_div(input logic [15:0] a, input logic [15:0] b);
        int         ma;
        int         mb;
        int         qv;
        int         e;
        int         frac;
        logic       s;
        logic [5:0] e6;
        logic [8:0] f9;
        if (a == 16'hFFFF || b == 16'hFFFF) return {1'b0, 16'hFFFF};
        if (b == 16'h0000) return {1'b1, 16'hFFFF};
        if (a == 16'h0000) return 17'h0;
        ma   = 512 + int'(a[8:0]);
        mb   = 512 + int'(b[8:0]);
        qv   = (ma * 1024) / mb;
        e    = int'(a[14:9]) - int'(b[14:9]) + ((qv >= 1024) ? 31 : 30);
        frac = (qv >= 1024) ? ((qv >> 1) % 512) : (qv % 512);
        s    = a[15] ^ b[15];
        if (e <= 0) return 17'h0;
        if (e == 63) return {1'b0, 16'hFFFF};
        if (e > 63) return {1'b0, (s ? 16'hFDFE : 16'h7DFE)};
        e6 = e[5:0];
        f9 = frac[8:0];
        return {1'b0, s, e6, f9};
    endfunction

    task automatic push_exp(input logic [15:0] c, input logic dz, input bit special);
        exp_t t;
        t.c    = c;
        t.dz   = dz;
        t.lat  = special ? 1 : 13;
        t.busy = special ? 0 : 12;
        sb.push_back(t);
    endtask

    // Called #1 after an edge; returns #1 after the start edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done; latency 1 means done seen right after the start edge.
    task automatic collect(output logic [15:0] oc, output logic odz, output int olat,
                           output int obusy, output bit to);
        oc    = 16'h0;
        odz   = 1'b0;
        olat  = 0;
        obusy = 0;
        to    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) begin
                oc   = bus.c_div;
                odz  = bus.div_zero;
                olat = i + 1;
                to   = 1'b0;
                break;
            end
            if (bus.busy === 1'b1) obusy++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 16'h0;
        bus.b     = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        total++; if (bus.c_div !== 16'h0) begin bad++; $display("FAIL reset_c_div got %h want 0000", bus.c_div); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        logic [15:0] ta[7] = '{16'h4300, 16'h4000, 16'hC100, 16'h7C00, 16'h0200, 16'hFC00, 16'h4000};
        logic [15:0] tb[7] = '{16'h4000, 16'h4100, 16'h3E00, 16'h0200, 16'h7C00, 16'h0200, 16'h4000};
        logic [15:0] tc[7] = '{16'h4100, 16'h3CAA, 16'hC100, 16'h7DFE, 16'h0000, 16'hFDFE, 16'h3E00};
        logic [15:0] oc;
        logic        odz;
        int          olat;
        int          obusy;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 7; i++) begin
            push_exp(tc[i], 1'b0, 1'b0);
            issue(ta[i], tb[i]);
            collect(oc, odz, olat, obusy, to);
            e = sb.pop_front();
            total++;
            if (to) begin
                bad++; $display("FAIL norm_done op%0d got no done want done", i);
            end else begin
                total++; if (oc !== e.c) begin bad++; $display("FAIL norm_c_div op%0d got %h want %h", i, oc, e.c); end
                total++; if (odz !== e.dz) begin bad++; $display("FAIL norm_div_zero op%0d got %b want %b", i, odz, e.dz); end
                total++; if (olat !== e.lat) begin bad++; $display("FAIL norm_latency op%0d got %0d want %0d", i, olat, e.lat); end
                total++; if (obusy !== e.busy) begin bad++; $display("FAIL norm_busy_cycles op%0d got %0d want %0d", i, obusy, e.busy); end
            end
            @(posedge clk);
            #1;
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL norm_done_pulse op%0d got %b want 0", i, bus.done); end
        end
    endtask

    task automatic test_special();
        logic [15:0] ta[6] = '{16'h4000, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000, 16'hFFFF};
        logic [15:0] tb[6] = '{16'h0000, 16'h1234, 16'h4000, 16'hFFFF, 16'h0000, 16'h0000};
        logic [15:0] tc[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic        td[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] oc;
        logic        odz;
        int          olat;
        int          obusy;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            push_exp(tc[i], td[i], 1'b1);
            issue(ta[i], tb[i]);
            collect(oc, odz, olat, obusy, to);
            e = sb.pop_front();
            total++;
            if (to) begin
                bad++; $display("FAIL spec_done op%0d got no done want done", i);
            end else begin
                total++; if (oc !== e.c) begin bad++; $display("FAIL spec_c_div op%0d got %h want %h", i, oc, e.c); end
                total++; if (odz !== e.dz) begin bad++; $display("FAIL spec_div_zero op%0d got %b want %b", i, odz, e.dz); end
                total++; if (olat !== e.lat) begin bad++; $display("FAIL spec_latency op%0d got %0d want %0d", i, olat, e.lat); end
            end
            repeat (3) @(posedge clk);
            #1;
            total++; if (bus.c_div !== e.c) begin bad++; $display("FAIL spec_c_div_held op%0d got %h want %h", i, bus.c_div, e.c); end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] oc;
        logic        odz;
        int          olat;
        int          obusy;
        bit          to;
        int          extra;
        exp_t        e;
        push_exp(16'h4100, 1'b0, 1'b0);
        issue(16'h4300, 16'h4000);
        repeat (4) @(posedge clk);
        #1;
        bus.a     = 16'h4000;
        bus.b     = 16'h0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        collect(oc, odz, olat, obusy, to);
        e = sb.pop_front();
        total++;
        if (to) begin
            bad++; $display("FAIL ign_done got no done want done");
        end else begin
            total++; if (oc !== e.c) begin bad++; $display("FAIL ign_c_div got %h want %h", oc, e.c); end
            total++; if (odz !== e.dz) begin bad++; $display("FAIL ign_div_zero got %b want %b", odz, e.dz); end
            total++; if (olat !== 8) begin bad++; $display("FAIL ign_latency got %0d want 8", olat); end
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_abort();
        logic [15:0] oc;
        logic        odz;
        int          olat;
        int          obusy;
        bit          to;
        int          extra;
        exp_t        e;
        issue(16'h4300, 16'h4000);
        collect(oc, odz, olat, obusy, to);
        total++; if (oc !== 16'h4100) begin bad++; $display("FAIL abort_pre_c_div got %h want 4100", oc); end
        @(posedge clk);
        #1;
        issue(16'h4300, 16'h4000);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", bus.done); end
        total++; if (bus.c_div !== 16'h0) begin bad++; $display("FAIL abort_c_div got %h want 0000", bus.c_div); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL abort_div_zero got %b want 0", bus.div_zero); end
        bus.a     = 16'h4000;
        bus.b     = 16'h0000;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            bad++; $display("FAIL abort_start_in_rst got done=%b dz=%b want 0 0", bus.done, bus.div_zero);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        extra     = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL abort_spurious_activity got %0d want 0", extra); end
        push_exp(16'h3CAA, 1'b0, 1'b0);
        issue(16'h4000, 16'h4100);
        collect(oc, odz, olat, obusy, to);
        e = sb.pop_front();
        total++;
        if (to) begin
            bad++; $display("FAIL abort_post_done got no done want done");
        end else begin
            total++; if (oc !== e.c) begin bad++; $display("FAIL abort_post_c_div got %h want %h", oc, e.c); end
            total++; if (olat !== e.lat) begin bad++; $display("FAIL abort_post_latency got %0d want %0d", olat, e.lat); end
            total++; if (obusy !== e.busy) begin bad++; $display("FAIL abort_post_busy got %0d want %0d", obusy, e.busy); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] oc;
        logic        odz;
        int          olat;
        int          obusy;
        bit          to;
        exp_t        e;
        logic [15:0] na;
        logic [15:0] nb;
        logic [16:0] m;
        int          mode;
        for (int k = 0; k < 30; k++) begin
            mode = int'($urandom_range(0, 9));
            na = {1'($urandom_range(0, 1)), 6'($urandom_range(18, 46)), 9'($urandom_range(0, 511))};
            nb = {1'($urandom_range(0, 1)), 6'($urandom_range(18, 46)), 9'($urandom_range(0, 511))};
            if (mode == 0) nb = 16'h0000;
            if (mode == 1) na = 16'h0000;
            if (mode == 2) na = 16'hFFFF;
            if (mode == 3) na = 16'($urandom_range(1, 65534));
            m = model_div(na, nb);
            push_exp(m[15:0], m[16], is_special(na, nb));
            bus.a     = na;
            bus.b     = nb;
            bus.start = 1'b1;
            if (k > 0) begin
                @(posedge clk);
                #1;
                total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    bad++; $display("FAIL b2b_start_in_done op%0d got busy=%b done=%b want 0 0", k, bus.busy, bus.done);
                end
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            collect(oc, odz, olat, obusy, to);
            e = sb.pop_front();
            total++;
            if (to) begin
                bad++; $display("FAIL b2b_done op%0d got no done want done", k);
            end else begin
                total++; if (oc !== e.c) begin bad++; $display("FAIL b2b_c_div op%0d a=%h b=%h got %h want %h", k, na, nb, oc, e.c); end
                total++; if (odz !== e.dz) begin bad++; $display("FAIL b2b_div_zero op%0d got %b want %b", k, odz, e.dz); end
                total++; if (olat !== e.lat) begin bad++; $display("FAIL b2b_latency op%0d got %0d want %0d", k, olat, e.lat); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_normal();
        test_special();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dl_div.md
DL_DIV -- requirements
Module: dl_div

Interface
REQ-001: The block SHALL use parameter-free ports; the DLFloat16 format is fixed: [15] sign, [14:9] exponent (bias 31), [8:0] fraction with hidden leading 1.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: start  input  1  request; sampled only in IDLE.
REQ-005: a  input  16  dividend, sampled with start.
REQ-006: b  input  16  divisor, sampled with start.
REQ-007: busy  output  1  high in DIV and NORM states.
REQ-008: done  output  1  one-cycle pulse; c_div valid while high.
REQ-009: c_div  output  16  registered quotient, held until next done.
REQ-010: div_zero  output  1  registered flag, updated with c_div; 1 iff the last result came from b==16'h0000.

Function
REQ-011: States SHALL be IDLE, DIV, NORM, DONE; done=1 only in DONE; DONE always returns to IDLE next cycle.
REQ-012: start in DIV, NORM or DONE SHALL be ignored; a/b SHALL be latched only on a start edge in IDLE.
REQ-013: Special cases SHALL be resolved on the start edge, in priority order: a or b ==16'hFFFF -> 16'hFFFF; b==0 -> 16'hFFFF with div_zero=1; a==0 -> 16'h0000; state goes directly to DONE (done in the cycle after the start edge).
REQ-014: Otherwise the start edge SHALL load rem={1,a[8:0]} (11 bits), div={1,b[8:0]}, clear 11-bit quotient q and 4-bit counter, sign s=a[15]^b[15], and enter DIV.
REQ-015: Each DIV cycle SHALL perform one restoring step: if rem>=div then q bit=1 and rem=rem-div, else q bit=0; then rem<<=1; q shifts left MSB-first.
REQ-016: DIV SHALL last exactly 11 cycles (counter 0..10), then enter NORM.
REQ-017: NORM SHALL compute signed 8-bit e=ea-eb+31 when q[10]=1 (fraction=q[9:1]), else e=ea-eb+30 (fraction=q[8:0]); truncation, no rounding.
REQ-018: NORM SHALL register c_div: e<=0 -> 16'h0000; e==63 -> 16'hFFFF; e>63 -> 16'h7DFE if s=0, 16'hFDFE if s=1; else {s,e[5:0],fraction}; div_zero=0; then enter DONE.
REQ-019: Normal-path latency SHALL be 13 cycles from start edge to done-high cycle; special-path latency 1 cycle.
REQ-020: Next start SHALL be accepted no earlier than the cycle after done (back-in IDLE).

Reset
REQ-021: rst=1 SHALL immediately force state=IDLE, busy=0, done=0, c_div=16'h0000, div_zero=0, counter/q/rem cleared, regardless of clk.
REQ-022: rst asserted mid-DIV or mid-NORM SHALL abort the operation with no done pulse; start is ignored while rst=1.
REQ-023: After rst deasserts, the first start in IDLE SHALL behave identically to a post-power-up start.

Verification
REQ-024: a=16'h4300 (6.0), b=16'h4000 (2.0), start 1 cycle -> busy 12 cycles, then done pulse with c_div=16'h4100, div_zero=0.
REQ-025: a=16'h4000, b=16'h4100 -> c_div=16'h3CAA (normalize path q[10]=0); a=16'hC100, b=16'h3E00 -> c_div=16'hC100.
REQ-026: a=16'h7C00, b=16'h0200 -> c_div=16'h7DFE; a=16'h0200, b=16'h7C00 -> c_div=16'h0000; 16'h7C00/16'h0200 with a[15]=1 -> 16'hFDFE.
REQ-027: a=16'h4000, b=16'h0000 -> done 1 cycle after start, c_div=16'hFFFF, div_zero=1; a=16'hFFFF with any b -> 16'hFFFF, div_zero=0; a=0, b=16'h4000 -> 16'h0000.
REQ-028: start pulsed again during busy -> ignored, result of first operation only; rst pulsed at DIV cycle 5 -> no done, outputs zero, next start completes correctly.
